pipe_adder: RTL and testbench
=============================

# pipe_adder

Parametrised, pipelined ripple-carry adder; the next generation of the 4-bit full-adder chain. It splits a WIDTH-bit add into STAGES registered chunks, so the carry chain is broken at register boundaries. It accepts one operand pair per cycle under a valid/ready handshake and sits between operand producers and result consumers in the datapath.

## Interface
- WIDTH, 32: operand/sum width; must be a multiple of STAGES.
- STAGES, 4: pipeline depth (≥1); chunk width CW = WIDTH/STAGES.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operand pair present.
- in_ready  out  1  pipe accepts the operand pair this cycle.
- carryin  in  1  carry into bit 0.
- X  in  WIDTH  operand A, unsigned.
- Y  in  WIDTH  operand B, unsigned.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- S  out  WIDTH  sum.
- carryout  out  1  carry out of bit WIDTH-1.
- overflow  out  1  signed overflow; present only with PIPE_ADD_OVF_EN.

## Operation
- Stage k (0..STAGES-1) adds chunk k of X and Y plus the carry registered by stage k-1. Stage 0 uses carryin.
- Each stage registers:
  - its CW-bit partial sum, plus all lower partial sums already produced;
  - the operand chunks not yet consumed (skew buffer);
  - its carry;
  - a valid bit v[k].
- Chunk arithmetic: {c_out, s_chunk} = x_chunk + y_chunk + c_in. Arithmetic is (CW+1)-bit, with no truncation of the carry.
- Per-stage advance: rdy[k] = !v[k] | rdy[k+1], with rdy[STAGES] = out_ready. in_ready = rdy[0] & !rst.
- Transfer in when in_valid & in_ready. Transfer out when out_valid & out_ready.
- S, carryout and out_valid are driven directly from the last stage's registers (out_valid = v[STAGES-1]).
- A stalled stage holds all of its registers. No bubbles are inserted and no data is dropped or duplicated.
- Full adds: 0xFFFF...F + 0 + 1 must give S = 0, carryout = 1. The carry ripples across every stage boundary.

## Timing
- Latency: STAGES cycles from accept to out_valid, when out_ready is held high.
- Throughput: 1 result/cycle with out_ready high.
- STAGES=1: behaves as a single registered adder with latency 1.
- Reset (async assert, synchronous-safe deassert on clk):
  - all v[k] = 0, all data registers = 0;
  - out_valid = 0, S = 0, carryout = 0, overflow = 0;
  - in_ready = 0 while rst is high, and 1 on the first cycle after release.
- Reset mid-operation: all in-flight results are discarded and nothing is emitted afterwards.
- Backpressure: out_ready low with the pipe full → in_ready = 0 in the same cycle (combinational through rdy chain).
- Simultaneous in and out transfer with the pipe full and out_ready high is allowed; occupancy is unchanged.
- out_valid, once high, stays high with S/carryout stable until accepted.

## Configuration
- PIPE_ADD_OVF_EN defined:
  - the last stage also registers the carry into the MSB;
  - overflow = carry_into_msb ^ carryout, valid with out_valid.
- Not defined: the overflow port and its logic are absent; all other behaviour is identical.

## Structure
- Package pipe_add_pkg holds:
  - function chunk_w(WIDTH, STAGES);
  - an elaboration-time check constant that WIDTH % STAGES == 0 (fatal otherwise).
- Sub-module add_stage holds one registered chunk:
  - parameters CW and LO (chunk base bit);
  - holds the v/data/carry registers and the rdy equation;
  - instantiated STAGES times via generate.

## Test plan
- WIDTH=16, STAGES=4, out_ready=1. Input X=0x1234, Y=0x4321, cin=0 → S=0x5555, carryout=0, exactly 4 cycles after accept.
- X=0xFFFF, Y=0x0000, cin=1 → S=0x0000, carryout=1; exercises carry crossing all 3 boundaries.
- Stream 100 random pairs back-to-back with out_ready=1 → results match the reference model in order, one per cycle, and in_ready stays high.
- Random out_ready toggling (50%) with in_valid always high → no loss or duplication. in_ready is low whenever the pipe is full and out_ready=0. S is held stable during stalls.
- Assert rst with 3 results in flight → out_valid=0 and S=0 immediately (async). After release, the next pair X=1, Y=1 yields S=2 with no stale outputs.
- With PIPE_ADD_OVF_EN: X=0x7FFF, Y=0x0001 → overflow=1. X=0x8000, Y=0x8000 → overflow=1, carryout=1. X=0xFFFF, Y=0x0001 → overflow=0.

Source files
------------

// File: rtl/pipe_add_pkg.sv
// pipe_add_pkg: shared helpers for the pipelined ripple-carry adder.
// Chunk width and the configuration legality check live here.
package pipe_add_pkg;

    function automatic int chunk_w(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/add_stage.sv
// add_stage: one registered CW-bit slice of the pipelined adder.
// Optional carry-into-MSB register with PIPE_ADD_OVF_EN.
module add_stage
    import pipe_add_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = 8,
    parameter int LO    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_v,
    input  logic             up_c,
    input  logic [WIDTH-1:0] up_x,
    input  logic [WIDTH-1:0] up_y,
    input  logic [WIDTH-1:0] up_s,
    input  logic             down_rdy,
    output logic             rdy,
    output logic             v,
    output logic             c,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] s
`ifdef PIPE_ADD_OVF_EN
    ,
    output logic             mc
`endif
);

    localparam logic [WIDTH-1:0] ONES = '1;
    // Operand bits above this chunk still need to travel downstream.
    localparam logic [WIDTH-1:0] KEEP = ONES << (LO + CW);

    logic [CW:0]      part;
    logic [WIDTH-1:0] s_next;

    assign part = {1'b0, up_x[LO +: CW]}
                + {1'b0, up_y[LO +: CW]}
                + {{CW{1'b0}}, up_c};

    always_comb begin
        s_next = up_s;
        s_next[LO +: CW] = part[CW-1:0];
    end

    assign rdy = !v | down_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= 1'b0;
            c <= 1'b0;
            x <= '0;
            y <= '0;
            s <= '0;
`ifdef PIPE_ADD_OVF_EN
            mc <= 1'b0;
`endif
        end else if (rdy) begin
            v <= up_v;
            if (up_v) begin
                c <= part[CW];
                x <= up_x & KEEP;
                y <= up_y & KEEP;
                s <= s_next;
`ifdef PIPE_ADD_OVF_EN
                mc <= up_x[LO+CW-1] ^ up_y[LO+CW-1] ^ part[CW-1];
`endif
            end
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit ripple-carry adder split into STAGES registered chunks.
// Define PIPE_ADD_OVF_EN to add the registered signed overflow output.
module pipe_adder
    import pipe_add_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             carryin,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             carryout
`ifdef PIPE_ADD_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW     = chunk_w(WIDTH, STAGES);
    localparam bit CFG_OK = cfg_ok(WIDTH, STAGES);

    if (!CFG_OK) begin : g_cfg_bad
        $fatal(1, "pipe_adder: WIDTH must be a multiple of STAGES >= 1");
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic             uv;
        logic             uc;
        logic             dr;
        logic             rdy;
        logic             vq;
        logic             cq;
        logic [WIDTH-1:0] ux;
        logic [WIDTH-1:0] uy;
        logic [WIDTH-1:0] us;
        logic [WIDTH-1:0] xq;
        logic [WIDTH-1:0] yq;
        logic [WIDTH-1:0] sq;
`ifdef PIPE_ADD_OVF_EN
        logic             mq;
`endif

        if (k == 0) begin : g_head
            assign uv = in_valid & in_ready;
            assign uc = carryin;
            assign ux = X;
            assign uy = Y;
            assign us = '0;
        end else begin : g_link
            assign uv = g_st[k-1].vq;
            assign uc = g_st[k-1].cq;
            assign ux = g_st[k-1].xq;
            assign uy = g_st[k-1].yq;
            assign us = g_st[k-1].sq;
        end

        // The tail's operand skew is fully consumed by now.
        if (k == STAGES - 1) begin : g_last
            logic unused_tail;
            assign dr = out_ready;
            assign unused_tail = ^{xq, yq};
        end else begin : g_mid
            assign dr = g_st[k+1].rdy;
`ifdef PIPE_ADD_OVF_EN
            logic unused_mq;
            assign unused_mq = mq;
`endif
        end

        add_stage #(
            .WIDTH (WIDTH),
            .CW    (CW),
            .LO    (k * CW)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_v     (uv),
            .up_c     (uc),
            .up_x     (ux),
            .up_y     (uy),
            .up_s     (us),
            .down_rdy (dr),
            .rdy      (rdy),
            .v        (vq),
            .c        (cq),
            .x        (xq),
            .y        (yq),
            .s        (sq)
`ifdef PIPE_ADD_OVF_EN
            ,
            .mc       (mq)
`endif
        );
    end

    assign in_ready  = g_st[0].rdy & !rst;
    assign out_valid = g_st[STAGES-1].vq;
    assign S         = g_st[STAGES-1].sq;
    assign carryout  = g_st[STAGES-1].cq;

`ifdef PIPE_ADD_OVF_EN
    assign overflow = g_st[STAGES-1].mq ^ g_st[STAGES-1].cq;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder at WIDTH=16, STAGES=4.
// Checks overflow too when PIPE_ADD_OVF_EN is defined.
module tb_pipe_adder;

    localparam int W = 16;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid = 1'b0;
    logic         carryin = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] X = '0;
    logic [W-1:0] Y = '0;
    logic         in_ready;
    logic         out_valid;
    logic         carryout;
    logic [W-1:0] S;
`ifdef PIPE_ADD_OVF_EN
    logic         overflow;
`endif

    pipe_adder #(
        .WIDTH  (W),
        .STAGES (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .carryin   (carryin),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .carryout  (carryout)
`ifdef PIPE_ADD_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W:0] exp;
        logic       ovf;
        int         cyc;
        bit         lat;
    } item_t;

    item_t        q[$];
    int           passes = 0;
    int           total = 0;
    int           cyc = 0;
    int           occ = 0;
    bit           lat_mode = 1'b0;
    bit           stream_mode = 1'b0;
    bit           held = 1'b0;
    logic [W-1:0] held_s;
    logic         held_c;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, want %0h", name, act, req);
    endtask

    function automatic item_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic ci, input int t, input bit l);
        item_t it;
        int    us;
        int    ss;
        us = int'(a) + int'(b) + int'(ci);
        ss = int'($signed(a)) + int'($signed(b)) + int'(ci);
        it.exp = us[W:0];
        it.ovf = (ss > 32767) || (ss < -32768);
        it.cyc = t;
        it.lat = l;
        return it;
    endfunction

    // Mid-cycle view of what the next rising edge will transfer.
    always @(negedge clk) begin
        item_t it;
        #2;
        if (!rst) begin
            if (held) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_hold_S", {16'd0, S}, {16'd0, held_s});
                check("stall_hold_cout", {31'd0, carryout}, {31'd0, held_c});
            end
            if (occ == N && !out_ready)
                check("full_backpressure", {31'd0, in_ready}, 32'd0);
            if (stream_mode)
                check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_output", {31'd0, out_valid}, 32'd0);
                end else begin
                    it = q.pop_front();
                    check("sum", {15'd0, carryout, S}, {15'd0, it.exp});
                    if (it.lat) check("latency", cyc - it.cyc, N);
`ifdef PIPE_ADD_OVF_EN
                    check("overflow", {31'd0, overflow}, {31'd0, it.ovf});
`endif
                    occ--;
                end
            end
            held   = out_valid && !out_ready;
            held_s = S;
            held_c = carryout;
            if (in_valid && in_ready) begin
                q.push_back(model(X, Y, carryin, cyc, lat_mode));
                occ++;
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci);
        @(negedge clk);
        in_valid = 1'b1;
        X = a;
        Y = b;
        carryin = ci;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain_done", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_S", {16'd0, S}, 32'd0);
        check("rst_cout", {31'd0, carryout}, 32'd0);
`ifdef PIPE_ADD_OVF_EN
        check("rst_ovf", {31'd0, overflow}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        out_ready = 1'b1;
        lat_mode  = 1'b1;
        send(16'h1234, 16'h4321, 1'b0);
        drain();
        send(16'hFFFF, 16'h0000, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0);
        send(16'h8000, 16'h8000, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0);
        drain();

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            stream_mode = 1'b1;
            X = W'($urandom);
            Y = W'($urandom);
            carryin = 1'($urandom);
        end
        @(negedge clk);
        in_valid    = 1'b0;
        stream_mode = 1'b0;
        drain();

        lat_mode = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            X = W'($urandom);
            Y = W'($urandom);
            carryin = 1'($urandom);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            X = W'($urandom);
            Y = W'($urandom);
            carryin = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #4 rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_S", {16'd0, S}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        q.delete();
        occ  = 0;
        held = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lat_mode = 1'b1;
        send(16'h0001, 16'h0001, 1'b0);
        drain();
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
